// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared types for the ALU arbiter slice.
//   word_t   : 32-bit datapath word.
//   aluop_t  : 4-bit ALU operation code.
//   rr_wrap  : helper that folds an index back into 0..n-1.
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return idx % n;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Requester-side bundle of the ALU arbiter.
//   req_valid/req_ready        : per-requester request handshake
//   req_porta/portb/aluop      : per-requester operands and opcode
//   rsp_valid/rsp_ready        : per-requester response handshake
//   rsp_result/neg/ovf/zero/id : shared captured ALU response and owner index
// Modports: master = requesters, slave = arbiter.
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
);
    import alu_arbiter_pkg::*;

    logic   [NREQ-1:0] req_valid;
    logic   [NREQ-1:0] req_ready;
    word_t  [NREQ-1:0] req_porta;
    word_t  [NREQ-1:0] req_portb;
    aluop_t [NREQ-1:0] req_aluop;
    logic   [NREQ-1:0] rsp_valid;
    logic   [NREQ-1:0] rsp_ready;
    word_t             rsp_result;
    logic              rsp_neg;
    logic              rsp_ovf;
    logic              rsp_zero;
    logic   [IDW-1:0]  rsp_id;

    modport master (
        output req_valid, req_porta, req_portb, req_aluop, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_neg, rsp_ovf, rsp_zero, rsp_id
    );

    modport slave (
        input  req_valid, req_porta, req_portb, req_aluop, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_neg, rsp_ovf, rsp_zero, rsp_id
    );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// alu_arbiter_rr_picker
// Combinational round-robin pick: scans i_valid starting at i_ptr, wrapping
// modulo NREQ, and reports the first set requester.
//   i_valid : request vector
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot winner (zero when nothing valid)
//   o_idx   : winner index (0 when nothing valid)
//   o_any   : any requester valid
// ----------------------------------------------------------------------------
module alu_arbiter_rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int unsigned w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_j = rr_wrap(32'(i_ptr) + i, NREQ);
            if (!o_any && i_valid[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDW'(w_j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU among NREQ requesters. Operands are registered
// before the ALU and its result is captured after it, so one operation takes
// accept edge -> EXEC -> RESP (2 edges). Round-robin arbitration, one
// transaction in flight.
//   CLK, nRST               : clock, asynchronous active-low reset
//   bus (slave)             : requester handshakes and response bundle
//   alu_porta/portb/op      : ALU operand drive (0 outside EXEC)
//   alu_out/neg/ovf/zero    : ALU result inputs
//   busy                    : state is not IDLE
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    alu_arbiter_if.slave bus,
    output word_t        alu_porta,
    output word_t        alu_portb,
    output aluop_t       alu_op,
    input  word_t        alu_out,
    input  logic         alu_neg,
    input  logic         alu_ovf,
    input  logic         alu_zero,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} arb_state_t;

    arb_state_t       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    word_t            r_porta;
    word_t            r_portb;
    aluop_t           r_op;
    word_t            r_result;
    logic             r_neg;
    logic             r_ovf;
    logic             r_zero;
    logic [IDW-1:0]   r_rsp_id;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [NREQ-1:0]  w_rsp_sel;
    logic             w_rsp_done;
    logic             w_can_accept;
    logic             w_accept;
    logic [IDW-1:0]   w_next_ptr;
    word_t            w_sel_porta;
    word_t            w_sel_portb;
    aluop_t           w_sel_op;

    alu_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Decode owner index to one-hot; avoids indexing NREQ-wide vectors with IDW bits.
    always_comb begin
        w_rsp_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_rsp_sel[i] = (r_rsp_id == IDW'(i));
        end
    end

    // Only the owner's rsp_ready can complete the response.
    assign w_rsp_done   = (r_state == StResp) && |(bus.rsp_ready & w_rsp_sel);
    // nRST gates the grant so req_ready reads 0 while reset is held.
    assign w_can_accept = nRST && ((r_state == StIdle) || w_rsp_done);
    assign w_accept     = w_can_accept && w_any;
    assign w_next_ptr   = IDW'(rr_wrap(32'(w_idx) + 1, NREQ));

    always_comb begin
        w_sel_porta = '0;
        w_sel_portb = '0;
        w_sel_op    = ALU_SLL;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_porta = bus.req_porta[i];
                w_sel_portb = bus.req_portb[i];
                w_sel_op    = bus.req_aluop[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_porta  <= '0;
            r_portb  <= '0;
            r_op     <= ALU_SLL;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_rsp_id <= '0;
        end else begin
            unique case (r_state)
                StIdle, StResp: begin
                    if (w_accept) begin
                        r_porta <= w_sel_porta;
                        r_portb <= w_sel_portb;
                        r_op    <= w_sel_op;
                        r_owner <= w_idx;
                        r_ptr   <= w_next_ptr;
                        r_state <= StExec;
                    end else if (w_rsp_done) begin
                        r_state <= StIdle;
                    end
                end
                StExec: begin
                    r_result <= alu_out;
                    r_neg    <= alu_neg;
                    r_ovf    <= alu_ovf;
                    r_zero   <= alu_zero;
                    r_rsp_id <= r_owner;
                    r_state  <= StResp;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = w_can_accept ? w_grant : '0;
    assign bus.rsp_valid  = (r_state == StResp) ? w_rsp_sel : '0;
    assign bus.rsp_result = r_result;
    assign bus.rsp_neg    = r_neg;
    assign bus.rsp_ovf    = r_ovf;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_id     = r_rsp_id;

    assign alu_porta = (r_state == StExec) ? r_porta : '0;
    assign alu_portb = (r_state == StExec) ? r_portb : '0;
    assign alu_op    = (r_state == StExec) ? r_op : ALU_SLL;
    assign busy      = (r_state != StIdle);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (PortA, PortB, ALUOP in; OutputPort, Negative, Overflow, Zero out) among NREQ requesters, for example the execute stage, a branch-compare unit and a debug/test port.
- Round-robin arbitration with a valid/ready request handshake and a held response handshake.
- Drives the ALU from registered operands and captures the ALU result into registers, so the ALU sits between two register stages.

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- IDW, 2, width of the grant-index field; must satisfy 2**IDW >= NREQ.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_porta  in  NREQ x 32  operand A per requester.
- req_portb  in  NREQ x 32  operand B per requester.
- req_aluop  in  NREQ x 4  ALU operation code (aluop_t) per requester.
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  32  captured OutputPort.
- rsp_neg, rsp_ovf, rsp_zero  out  1 each  captured Negative, Overflow, Zero.
- rsp_id  out  IDW  index of the requester that owns the current response.
- alu_porta, alu_portb  out  32 each  drive ALU PortA and PortB.
- alu_op  out  4  drive ALU ALUOP.
- alu_out  in  32  ALU OutputPort.
- alu_neg, alu_ovf, alu_zero  in  1 each  ALU flags.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, nRST=0):
  - State IDLE; round-robin pointer 0.
  - Operand, opcode, result, flag and rsp_id registers cleared to 0.
  - All outputs 0.
  - Reset mid-operation drops any in-flight request with no response issued.
- States:
  - IDLE: no transaction in flight.
  - EXEC: operands registered; ALU being evaluated.
  - RESP: result held for the owner.
- Arbitration (combinational, IDLE or RESP-completing cycle only):
  - Scan requesters starting at the pointer, wrapping modulo NREQ.
  - The first requester with req_valid=1 wins.
  - req_ready[win]=1 in the same cycle. A transfer occurs when req_valid & req_ready are both high.
- Accept edge: latch req_porta, req_portb, req_aluop and the winner index; pointer <= (win+1) mod NREQ; state -> EXEC.
- EXEC (exactly 1 cycle):
  - alu_porta, alu_portb, alu_op driven from the registers. They are 0 in all other states.
  - Edge: capture alu_out and flags into rsp_* registers; rsp_id <= owner; state -> RESP.
- RESP:
  - rsp_valid[rsp_id]=1. rsp_result, flags and rsp_id stay stable until the handshake completes.
  - If rsp_ready[rsp_id]=1 and any req_valid: arbitrate and accept in the same cycle; state -> EXEC (back-to-back, one op per 2 cycles).
  - If rsp_ready[rsp_id]=1 and no req_valid: -> IDLE.
  - If rsp_ready=0: stay in RESP; req_ready all 0.
- Latency: accept edge to rsp_valid high = 2 rising edges.
- Per-requester order is preserved: at most one transaction is in flight.
- rsp_ready bits for non-owners are ignored.
- An ALU overflow is only reported via rsp_ovf. It causes no other side effect.
- req_valid dropped without acceptance is legal; nothing is recorded.

Decomposition:
- The shared cpu_types_pkg holds aluop_t (4-bit ALU opcode enum) and word_t (32-bit).
- A local arb_state_t enum (IDLE, EXEC, RESP) lives in the module.
- One natural sub-module is rr_picker: parameterised NREQ round-robin pick from req_valid and the pointer, outputting a one-hot grant plus index. It is purely combinational and reusable by other arbiters.

Test Plan:
- Reset: hold nRST=0 with req_valid=2'b11. Required: req_ready=0, rsp_valid=0, alu_op=0, busy=0. Release reset, then req0 requests ADD 5+7. Required: accept on the first cycle, rsp_valid=2'b01 two edges later, rsp_result=12, rsp_zero=0.
- Contention: req0 and req1 both held valid, rsp_ready tied to 1. Grants alternate 0,1,0,1 starting at 0. A new accept occurs every 2 cycles. rsp_id follows the grant sequence.
- Backpressure: req1 performs SUB 3-3, rsp_ready=0 for 5 cycles. Required: rsp_valid[1], rsp_result=0 and rsp_zero=1 stay stable for all 5 cycles; req_ready=0 throughout; release gives a single completion.
- Overflow/negative: ADD 0x7FFFFFFF+1. Required: rsp_result=0x80000000, rsp_ovf=1, rsp_neg=1.
- Reset mid-operation: assert nRST=0 during EXEC. Required: outputs 0 immediately (async), and after release no response appears for the dropped request.
- Wrap-around (NREQ=3): req2 is accepted first, then req0 and req2 are valid. Required: the pointer wraps to 0, so req0 wins next.
